// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_e;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  localparam int PERF_CNT_W = 16;

  // Saturating increment for the optional performance counters.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order tag FIFO holding the requester ID of every outstanding memory request.
// The head is read combinationally so responses can be steered with zero latency.
module mem_arb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one in-order valid/ready memory between NUM_REQ requesters.
// Optional per-requester grant and stall counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_OUTST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_val_i,
  input  logic [NUM_REQ-1:0]            req_typ_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_rdy_o,
  output logic [NUM_REQ-1:0]            rsp_val_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  input  logic [NUM_REQ-1:0]            rsp_rdy_i,
  output logic                          mem_req_val_o,
  output logic                          mem_req_typ_o,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_req_data_o,
  input  logic                          mem_req_rdy_i,
  input  logic                          mem_rsp_val_i,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data_i,
  output logic                          mem_rsp_rdy_o,
  output logic                          err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_W-1:0] grant_cnt_o,
  output logic [PERF_CNT_W-1:0]         stall_cnt_o
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e      state_reg, state_next;
  logic [ID_W-1:0] last_reg;
  logic [ID_W-1:0] gnt_reg;
  logic            err_reg;
  logic [ID_W-1:0] rr_winner;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] head_id;
  logic            req_val_int;
  logic            req_acc;
  logic            rsp_acc;
  logic            fifo_full;
  logic            fifo_empty;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    rr_winner = last_reg;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_reg) + k) % NUM_REQ);
      if (!found && req_val_i[cand]) begin
        rr_winner = cand;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel         = rr_winner;
    req_val_int = 1'b0;
    case (state_reg)
      ARB: begin
        sel         = rr_winner;
        req_val_int = (|req_val_i) && !fifo_full;
        if (req_val_int && !mem_req_rdy_i) state_next = HOLD;
      end
      HOLD: begin
        sel         = gnt_reg;
        req_val_int = req_val_i[gnt_reg] && !fifo_full;
        if (mem_req_rdy_i) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  assign req_acc        = req_val_int && mem_req_rdy_i;
  assign mem_req_val_o  = req_val_int;
  assign mem_req_typ_o  = req_val_int ? req_typ_i[sel] : REQ_RD;
  assign mem_req_addr_o = req_val_int ? req_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_req_data_o = req_val_int ? req_data_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign mem_rsp_rdy_o = !fifo_empty && rsp_rdy_i[head_id];
  assign rsp_acc       = mem_rsp_val_i && mem_rsp_rdy_o;
  assign rsp_data_o    = mem_rsp_data_i;
  assign err_o         = err_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign req_rdy_o[gi] = req_acc && (sel == ID_W'(gi));
      assign rsp_val_o[gi] = mem_rsp_val_i && !fifo_empty && (head_id == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ARB;
      last_reg  <= ID_W'(NUM_REQ - 1);
      gnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ARB && state_next == HOLD) gnt_reg <= sel;
      if (req_acc) last_reg <= sel;
      if (mem_rsp_val_i && fifo_empty) err_reg <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (req_acc),
    .push_data (sel),
    .pop       (rsp_acc),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] grant_cnt_reg [NUM_REQ];
  logic [PERF_CNT_W-1:0] stall_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          grant_cnt_reg[gi] <= '0;
        end else if (req_acc && sel == ID_W'(gi)) begin
          grant_cnt_reg[gi] <= sat_inc(grant_cnt_reg[gi]);
        end
      end
      assign grant_cnt_o[gi*PERF_CNT_W +: PERF_CNT_W] = grant_cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == HOLD) begin
      stall_cnt_reg <= sat_inc(stall_cnt_reg);
    end
  end
  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses,
// negedge monitors pop and compare on every request and response handshake.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int MO = 4;

  logic            clk_i;
  logic            rst_i;
  logic [NR-1:0]   req_val_i;
  logic [NR-1:0]   req_typ_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]   req_rdy_o;
  logic [NR-1:0]   rsp_val_o;
  logic [DW-1:0]   rsp_data_o;
  logic [NR-1:0]   rsp_rdy_i;
  logic            mem_req_val_o;
  logic            mem_req_typ_o;
  logic [AW-1:0]   mem_req_addr_o;
  logic [DW-1:0]   mem_req_data_o;
  logic            mem_req_rdy_i;
  logic            mem_rsp_val_i;
  logic [DW-1:0]   mem_rsp_data_i;
  logic            mem_rsp_rdy_o;
  logic            err_o;
`ifdef MEM_ARB_PERF_EN
  logic [NR*PERF_CNT_W-1:0] grant_cnt_o;
  logic [PERF_CNT_W-1:0]    stall_cnt_o;
`endif

  mem_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_OUTST  (MO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_val_i      (req_val_i),
    .req_typ_i      (req_typ_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_rdy_o      (req_rdy_o),
    .rsp_val_o      (rsp_val_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_rdy_i      (rsp_rdy_i),
    .mem_req_val_o  (mem_req_val_o),
    .mem_req_typ_o  (mem_req_typ_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_data_o (mem_req_data_o),
    .mem_req_rdy_i  (mem_req_rdy_i),
    .mem_rsp_val_i  (mem_rsp_val_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .mem_rsp_rdy_o  (mem_rsp_rdy_o),
    .err_o          (err_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .grant_cnt_o    (grant_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  typedef struct {
    int            id;
    logic          typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gnt_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic typ, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_typ_i[i]           = typ;
    req_addr_i[i*AW +: AW] = a;
    req_data_i[i*DW +: DW] = d;
  endtask

  task automatic want_gnt(input int i, input logic typ, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    gnt_t g;
    g.id = i; g.typ = typ; g.addr = a; g.data = d;
    exp_gnt.push_back(g);
  endtask

  task automatic want_rsp(input int i, input logic [DW-1:0] d);
    rsp_t r;
    r.id = i; r.data = d;
    exp_rsp.push_back(r);
  endtask

  task automatic do_reset();
    req_val_i     = '0;
    mem_rsp_val_i = 1'b0;
    mem_req_rdy_i = 1'b0;
    rsp_rdy_i     = '0;
    rst_i         = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  // Request-side monitor
  always @(negedge clk_i) begin
    gnt_t g;
    if (!rst_i && mem_req_val_o && mem_req_rdy_i) begin
      if (exp_gnt.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL gnt_unexpected: got req_rdy %b expected no grant", req_rdy_o);
      end else begin
        g = exp_gnt.pop_front();
        $display("gnt  req_rdy=%b typ=%0d addr=%0d data=%0h", req_rdy_o, mem_req_typ_o,
                 mem_req_addr_o, mem_req_data_o);
        chk("gnt_onehot", 64'(req_rdy_o), 64'(1) << g.id);
        chk("gnt_typ", 64'(mem_req_typ_o), 64'(g.typ));
        chk("gnt_addr", 64'(mem_req_addr_o), 64'(g.addr));
        chk("gnt_data", 64'(mem_req_data_o), 64'(g.data));
      end
    end
  end

  // Response-side monitor
  always @(negedge clk_i) begin
    rsp_t r;
    if (!rst_i && mem_rsp_val_i && mem_rsp_rdy_o) begin
      if (exp_rsp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_val %b expected no response", rsp_val_o);
      end else begin
        r = exp_rsp.pop_front();
        $display("rsp  rsp_val=%b data=%0h", rsp_val_o, rsp_data_o);
        chk("rsp_onehot", 64'(rsp_val_o), 64'(1) << r.id);
        chk("rsp_data", 64'(rsp_data_o), 64'(r.data));
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int ord[5];
    ord = '{0, 1, 2, 3, 0};
    rst_i          = 1'b1;
    req_val_i      = '0;
    req_typ_i      = '0;
    req_addr_i     = '0;
    req_data_i     = '0;
    rsp_rdy_i      = '0;
    mem_req_rdy_i  = 1'b0;
    mem_rsp_val_i  = 1'b0;
    mem_rsp_data_i = '0;
    #3;
    chk("rst_req_rdy", 64'(req_rdy_o), 64'h0);
    chk("rst_rsp_val", 64'(rsp_val_o), 64'h0);
    chk("rst_mem_req_val", 64'(mem_req_val_o), 64'h0);
    chk("rst_mem_rsp_rdy", 64'(mem_rsp_rdy_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_mem_req_addr", 64'(mem_req_addr_o), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data_o), 64'h0);
    step();
    rst_i = 1'b0;

    // 1: single read from requester 2
    set_req(2, REQ_RD, 7'd5, 32'h0);
    req_val_i     = 4'b0100;
    mem_req_rdy_i = 1'b1;
    rsp_rdy_i     = 4'b1111;
    want_gnt(2, REQ_RD, 7'd5, 32'h0);
    step();
    req_val_i      = '0;
    mem_rsp_val_i  = 1'b1;
    mem_rsp_data_i = 32'hDEAD;
    want_rsp(2, 32'hDEAD);
    step();
    mem_rsp_val_i = 1'b0;
    @(negedge clk_i);
    chk("t1_err", 64'(err_o), 64'h0);
    chk("t1_rsp_idle", 64'(rsp_val_o), 64'h0);
    step();

    // 2: round-robin with all requesters valid and immediate responses
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, i[0], AW'(10 + i), DW'(100 + i));
    for (int c = 0; c < 5; c++) want_gnt(ord[c], ord[c][0], AW'(10 + ord[c]), DW'(100 + ord[c]));
    req_val_i     = 4'b1111;
    mem_req_rdy_i = 1'b1;
    rsp_rdy_i     = 4'b1111;
    for (int c = 0; c <= 5; c++) begin
      if (c >= 1) begin
        mem_rsp_val_i  = 1'b1;
        mem_rsp_data_i = 32'hA000 + 32'(c);
        want_rsp(ord[c-1], 32'hA000 + 32'(c));
      end
      if (c == 5) req_val_i = '0;
      step();
    end
    mem_rsp_val_i = 1'b0;

    // 3: backpressure holds the grant on requester 2
    do_reset();
    set_req(2, REQ_WR, 7'd33, 32'd222);
    set_req(3, REQ_RD, 7'd44, 32'd333);
    set_req(1, REQ_WR, 7'd55, 32'd111);
    req_val_i = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) req_val_i[1] = 1'b1;
      @(negedge clk_i);
      chk("t3_hold_val", 64'(mem_req_val_o), 64'h1);
      chk("t3_hold_addr", 64'(mem_req_addr_o), 64'd33);
      chk("t3_hold_data", 64'(mem_req_data_o), 64'd222);
      chk("t3_hold_rdy", 64'(req_rdy_o), 64'h0);
      step();
    end
    mem_req_rdy_i = 1'b1;
    want_gnt(2, REQ_WR, 7'd33, 32'd222);
    step();
    req_val_i[2] = 1'b0;
    want_gnt(3, REQ_RD, 7'd44, 32'd333);
    step();
    req_val_i[3] = 1'b0;
    want_gnt(1, REQ_WR, 7'd55, 32'd111);
    step();
    req_val_i = '0;
    step();

    // 4: tag FIFO full blocks requests until a response drains one entry
    do_reset();
    set_req(0, REQ_WR, 7'd20, 32'd500);
    req_val_i     = 4'b0001;
    mem_req_rdy_i = 1'b1;
    rsp_rdy_i     = 4'b1111;
    for (int k = 0; k < MO; k++) begin
      req_addr_i[0 +: AW] = AW'(20 + k);
      want_gnt(0, REQ_WR, AW'(20 + k), 32'd500);
      step();
    end
    req_addr_i[0 +: AW] = 7'd30;
    @(negedge clk_i);
    chk("t4_full_val", 64'(mem_req_val_o), 64'h0);
    chk("t4_full_rdy", 64'(req_rdy_o), 64'h0);
    step();
    mem_rsp_val_i  = 1'b1;
    mem_rsp_data_i = 32'hBEEF;
    want_rsp(0, 32'hBEEF);
    @(negedge clk_i);
    chk("t4_full_pop_val", 64'(mem_req_val_o), 64'h0);
    step();
    mem_rsp_val_i = 1'b0;
    want_gnt(0, REQ_WR, 7'd30, 32'd500);
    @(negedge clk_i);
    chk("t4_after_pop_val", 64'(mem_req_val_o), 64'h1);
    step();
    req_val_i = '0;

    // 5: orphan response sets the sticky error
    do_reset();
    rsp_rdy_i      = 4'b1111;
    mem_rsp_val_i  = 1'b1;
    mem_rsp_data_i = 32'h5555;
    @(negedge clk_i);
    chk("t5_orphan_rdy", 64'(mem_rsp_rdy_o), 64'h0);
    chk("t5_orphan_val", 64'(rsp_val_o), 64'h0);
    step();
    mem_rsp_val_i = 1'b0;
    @(negedge clk_i);
    chk("t5_err_set", 64'(err_o), 64'h1);
    step();
    step();
    chk("t5_err_sticky", 64'(err_o), 64'h1);
    do_reset();
    chk("t5_err_clear", 64'(err_o), 64'h0);

    // 6: reset with two requests outstanding
    set_req(1, REQ_RD, 7'd66, 32'h0);
    req_val_i     = 4'b0010;
    mem_req_rdy_i = 1'b1;
    want_gnt(1, REQ_RD, 7'd66, 32'h0);
    want_gnt(1, REQ_RD, 7'd66, 32'h0);
    step();
    step();
    req_val_i      = '0;
    rsp_rdy_i      = '0;
    mem_rsp_val_i  = 1'b1;
    mem_rsp_data_i = 32'h7777;
    @(negedge clk_i);
    chk("t6_pre_rsp_val", 64'(rsp_val_o), 64'b0010);
    chk("t6_pre_rsp_rdy", 64'(mem_rsp_rdy_o), 64'h0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_async_rsp_val", 64'(rsp_val_o), 64'h0);
    chk("t6_async_mem_rsp_rdy", 64'(mem_rsp_rdy_o), 64'h0);
    chk("t6_async_req_val", 64'(mem_req_val_o), 64'h0);
    chk("t6_async_err", 64'(err_o), 64'h0);
    mem_rsp_val_i = 1'b0;
    step();
    rst_i = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, REQ_RD, AW'(70 + i), DW'(i));
    req_val_i = 4'b1111;
    rsp_rdy_i = 4'b1111;
    want_gnt(0, REQ_RD, 7'd70, 32'd0);
    step();
    req_val_i      = '0;
    mem_rsp_val_i  = 1'b1;
    mem_rsp_data_i = 32'h1234;
    want_rsp(0, 32'h1234);
    step();
    mem_rsp_val_i = 1'b0;
    @(negedge clk_i);
    chk("t6_err_after", 64'(err_o), 64'h0);
    step();

    chk("sb_gnt_drained", 64'(exp_gnt.size()), 64'h0);
    chk("sb_rsp_drained", 64'(exp_rsp.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one single-port, in-order, valid/ready memory between `NUM_REQ` requesters. It sits directly in front of the memory: it forwards one granted request per transfer, records the granted requester ID in an in-order tag FIFO, and steers each memory response back to the requester that issued it. Throughput is one request and one response per cycle, bounded by `MAX_OUTST` outstanding transactions.

## Interface

**Parameters**

- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: data width.
- `ADDR_WIDTH`, 7: word address width.
- `MAX_OUTST`, 4: tag FIFO depth (outstanding requests), power of two.
- `ID_W`, localparam `$clog2(NUM_REQ)`.

**Ports** (`req_*` and `rsp_*` are packed per requester; index `i` belongs to requester `i`)

- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_val_i`  in  NUM_REQ  request valid.
- `req_typ_i`  in  NUM_REQ  0 = read, 1 = write.
- `req_addr_i`  in  NUM_REQ×ADDR_WIDTH  address.
- `req_data_i`  in  NUM_REQ×DATA_WIDTH  write data.
- `req_rdy_o`  out  NUM_REQ  request accepted.
- `rsp_val_o`  out  NUM_REQ  response valid.
- `rsp_data_o`  out  DATA_WIDTH  response data, shared by all requesters.
- `rsp_rdy_i`  in  NUM_REQ  response ready.
- `mem_req_val_o` / `mem_req_typ_o` / `mem_req_addr_o` / `mem_req_data_o`  out  1/1/ADDR_WIDTH/DATA_WIDTH  request to the memory.
- `mem_req_rdy_i`  in  1  memory accepts the request.
- `mem_rsp_val_i`  in  1  memory response valid.
- `mem_rsp_data_i`  in  DATA_WIDTH  memory response data.
- `mem_rsp_rdy_o`  out  1  arbiter accepts the response.
- `err_o`  out  1  sticky flag: a response arrived while no transaction was outstanding.

## Operation

**Arbitration (round-robin)**
- Search order starts at `last_q+1` and wraps modulo `NUM_REQ`.
- `last_q` updates to the granted index only on an accepted memory request, i.e. `mem_req_val_o && mem_req_rdy_i`.
- A requester that is not valid is skipped with no penalty.

**Grant FSM**
- States: `ARB` and `HOLD`.
- `ARB`: `mem_req_val_o = |req_val_i && !fifo_full`. The memory request fields are muxed from the winner.
  - If `mem_req_rdy_i = 0`, register the winner in `gnt_q` and go to `HOLD`.
- `HOLD`: the request stays fixed to `gnt_q` (no re-arbitration) until `mem_req_rdy_i = 1`, then go to `ARB`.
  - Requesters must hold valid and payload stable until their ready; the arbiter does not check this.
- `req_rdy_o[g] = mem_req_rdy_i` for the granted `g` while `mem_req_val_o` is high. All other bits are 0.

**Tag FIFO**
- Push: the granted ID, on every accepted memory request.
- Pop: on every response handshake, `mem_rsp_val_i && mem_rsp_rdy_o`.
- Full: `mem_req_val_o` is forced to 0. A push into a full FIFO is forbidden even if a pop happens in the same cycle; this keeps the response path out of the request path.
- Simultaneous push and pop when not full is legal; the count is unchanged.

**Response steering**
- `h` is the FIFO head.
- `rsp_val_o[h] = mem_rsp_val_i && !fifo_empty`.
- `rsp_data_o = mem_rsp_data_i`.
- `mem_rsp_rdy_o = rsp_rdy_i[h] && !fifo_empty`.
- Empty FIFO with `mem_rsp_val_i = 1`: `mem_rsp_rdy_o = 0`, no `rsp_val_o` is asserted, and `err_o` sets. `err_o` clears only on reset.

## Timing

- **Reset values:** all `req_rdy_o`, `rsp_val_o`, `mem_req_val_o`, `mem_rsp_rdy_o`, `err_o` = 0 (with `req_val_i = 0`); `rsp_data_o` and `mem_req_*` = 0; FIFO empty; `last_q = NUM_REQ-1`, so requester 0 has first priority; FSM in `ARB`.
- **Request path:** combinational from `req_val_i` to `mem_req_*`, zero added latency.
- **Response path:** combinational, zero added latency.
- **State updates:** FIFO, `last_q`, `gnt_q` and FSM state update on the clock edge after a handshake.
- **Reset mid-operation:** FIFO pointers clear, so in-flight responses are orphaned. The memory must be reset together with the arbiter.
- **Pointer wrap:** FIFO pointers are `$clog2(MAX_OUTST)+1` bits; the extra bit gives full/empty.

## Configuration

- `MEM_ARB_PERF_EN` defined:
  - adds output `grant_cnt_o`, NUM_REQ×16 bits: per-requester count of accepted requests, saturating at `16'hFFFF`, cleared by reset;
  - adds output `stall_cnt_o`, 16 bits: cycles spent in `HOLD`, same saturating and reset behaviour.
- Undefined: neither port nor any counter logic exists.

## Structure

- Package `mem_arb_pkg`:
  - `typedef enum logic {ARB, HOLD} arb_state_e`;
  - request-type constants `REQ_RD = 1'b0`, `REQ_WR = 1'b1`;
  - counter width constant `PERF_CNT_W = 16`.
- Sub-module `mem_arb_id_fifo`: synchronous FIFO, parameterised width `ID_W` and depth `MAX_OUTST`, with `full` and `empty` outputs.

## Test plan

1. **Single read:** reset, then `req_val_i = 4'b0100`, read, addr 5; memory responds with `0xDEAD` -> `req_rdy_o = 4'b0100`; `rsp_val_o = 4'b0100` with `rsp_data_o = 0xDEAD`; `err_o = 0`.
2. **Round-robin:** all four requesters valid continuously, `mem_req_rdy_i = 1`, responses returned immediately -> grant order 0, 1, 2, 3, 0; each `req_rdy_o` bit one-hot.
3. **Backpressure:** `mem_req_rdy_i = 0` for 3 cycles while requester 2 is granted and requester 1 raises valid -> grant stays on 2, with unchanged payload, until ready; then requester 3 is granted, then 1.
4. **FIFO full:** `MAX_OUTST = 4`, 4 requests accepted, responses withheld -> `mem_req_val_o = 0`; one response returns -> the next request is accepted on the following cycle.
5. **Orphan response:** `mem_rsp_val_i = 1` with the FIFO empty -> `mem_rsp_rdy_o = 0`, `rsp_val_o = 0`, `err_o = 1` until `rst_i`.
6. **Reset mid-operation:** assert `rst_i` with 2 requests outstanding -> all outputs 0 asynchronously; after release, requester 0 has priority and the FIFO is empty.
